// File: rtl/operand_collector_if.sv
// operand_collector_if
//   Bundles the upstream byte handshake, the downstream frame handshake,
//   the flush control and the frame counter of operand_collector.
//
//   Handshake rule (both sides): a transfer happens on a rising clock edge
//   where valid and ready are both 1. A producer holds its data until that
//   edge. Ready never depends combinationally on valid.
//
//   Signals
//     i_flush      synchronous abort of a partially collected frame
//     i_valid      upstream byte valid
//     i_data[7:0]  upstream byte
//     o_ready      collector can take i_data this cycle
//     o_p0/1/2     collected operand bytes, arrival order
//     o_valid      o_p0..o_p2 hold a complete frame
//     i_ready      downstream accepts the frame
//     o_frame_cnt  frames handed downstream, modulo 256
//
//   Modports
//     slave   collector side
//     master  environment side (upstream producer + downstream consumer)
interface operand_collector_if;
  logic       i_flush;
  logic       i_valid;
  logic [7:0] i_data;
  logic       o_ready;
  logic [7:0] o_p0;
  logic [7:0] o_p1;
  logic [7:0] o_p2;
  logic       o_valid;
  logic       i_ready;
  logic [7:0] o_frame_cnt;

  modport slave (
    input  i_flush, i_valid, i_data, i_ready,
    output o_ready, o_p0, o_p1, o_p2, o_valid, o_frame_cnt
  );

  modport master (
    output i_flush, i_valid, i_data, i_ready,
    input  o_ready, o_p0, o_p1, o_p2, o_valid, o_frame_cnt
  );
endinterface

// File: rtl/operand_collector.sv
// operand_collector
//   Gathers three consecutive upstream bytes into one 3-operand frame and
//   hands that frame downstream with a valid/ready handshake.
//
//   Ports
//     i_clk      single clock, rising edge
//     i_rst      asynchronous active-high reset
//     bus        operand_collector_if.slave (handshakes, data, flush, count)
//     dbg_state  current FSM state encoding (S_B0=0, S_B1=1, S_B2=2, S_OUT=3)
//
//   Behaviour
//     Bytes 0 and 1 are parked in staging registers. The edge that accepts
//     byte 2 loads all three output operands at once and raises o_valid, so
//     the outputs only ever show complete frames. The operands then hold
//     until the next byte-2 accept, through handoff and flush alike.
//     A flush returns to S_B0 and wins over any same-edge accept or handoff.
module operand_collector (
  input  logic                       i_clk,
  input  logic                       i_rst,
  operand_collector_if.slave         bus,
  output logic [1:0]                 dbg_state
);

  typedef enum logic [1:0] {
    S_B0  = 2'd0,
    S_B1  = 2'd1,
    S_B2  = 2'd2,
    S_OUT = 2'd3
  } state_t;

  state_t     state;
  logic [7:0] staging0;
  logic [7:0] staging1;
  logic [7:0] p0;
  logic [7:0] p1;
  logic [7:0] p2;
  logic       valid;
  logic [7:0] frame_cnt;

  // Byte accept uses only the registered state for ready, so there is no
  // combinational path from i_valid or i_ready to o_ready.
  logic ready;
  assign ready = (state != S_OUT);

  logic accept;
  logic handoff;
  assign accept  = bus.i_valid & ready;
  assign handoff = valid & bus.i_ready;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state     <= S_B0;
      staging0  <= 8'h00;
      staging1  <= 8'h00;
      p0        <= 8'h00;
      p1        <= 8'h00;
      p2        <= 8'h00;
      valid     <= 1'b0;
      frame_cnt <= 8'h00;
    end else if (bus.i_flush) begin
      // Abort: partial bytes are thrown away, a pending frame is dropped
      // without counting it, and the visible operands keep their values.
      state    <= S_B0;
      staging0 <= 8'h00;
      staging1 <= 8'h00;
      valid    <= 1'b0;
    end else begin
      case (state)
        S_B0: begin
          if (accept) begin
            staging0 <= bus.i_data;
            state    <= S_B1;
          end
        end
        S_B1: begin
          if (accept) begin
            staging1 <= bus.i_data;
            state    <= S_B2;
          end
        end
        S_B2: begin
          if (accept) begin
            // Third byte bypasses staging and lands straight in p2.
            p0    <= staging0;
            p1    <= staging1;
            p2    <= bus.i_data;
            valid <= 1'b1;
            state <= S_OUT;
          end
        end
        S_OUT: begin
          if (handoff) begin
            valid     <= 1'b0;
            frame_cnt <= frame_cnt + 8'd1;
            state     <= S_B0;
          end
        end
        default: begin
          state <= S_B0;
          valid <= 1'b0;
        end
      endcase
    end
  end

  assign bus.o_ready     = ready;
  assign bus.o_valid     = valid;
  assign bus.o_p0        = p0;
  assign bus.o_p1        = p1;
  assign bus.o_p2        = p2;
  assign bus.o_frame_cnt = frame_cnt;
  assign dbg_state       = state;

endmodule

// File: doc/operand_collector.md
OPERAND_COLLECTOR -- requirements
Module: operand_collector

Interface
REQ-001 The block SHALL have parameter none; data width SHALL be fixed at 8 bits per operand.
REQ-002 i_clk  input  1  single clock, all state updates on rising edge.
REQ-003 i_rst  input  1  reset, asynchronous, active-high.
REQ-004 i_flush  input  1  synchronous abort of a partially collected frame.
REQ-005 i_valid  input  1  upstream byte valid.
REQ-006 i_data  input  8  upstream byte.
REQ-007 o_ready  output  1  block can accept i_data this cycle.
REQ-008 o_p0, o_p1, o_p2  output  8 each  collected operand bytes, in arrival order.
REQ-009 o_valid  output  1  o_p0..o_p2 hold a complete frame.
REQ-010 i_ready  input  1  downstream accepts the frame.
REQ-011 o_frame_cnt  output  8  count of frames handed downstream, modulo 256.

Function
REQ-012 Byte accept SHALL occur on a rising edge where i_valid=1 and o_ready=1; byte handoff SHALL occur on a rising edge where o_valid=1 and i_ready=1.
REQ-013 FSM states SHALL be S_B0 (awaiting byte 0), S_B1, S_B2, S_OUT.
REQ-014 Transitions: S_B0->S_B1, S_B1->S_B2, S_B2->S_OUT on byte accept; S_OUT->S_B0 on handoff; otherwise hold state.
REQ-015 o_ready SHALL be 1 in S_B0/S_B1/S_B2 and 0 in S_OUT, decoded from state only (no combinational path from i_ready or i_valid).
REQ-016 o_valid SHALL be 1 exactly in S_OUT, registered.
REQ-017 Bytes 0 and 1 SHALL go to internal staging registers; on byte-2 accept o_p0, o_p1, o_p2 SHALL load staging0, staging1, i_data in the same edge.
REQ-018 o_p0..o_p2 SHALL change only on a byte-2 accept and SHALL hold otherwise, including across handoff and flush.
REQ-019 Latency: o_valid SHALL rise on the edge accepting byte 2; minimum frame period SHALL be 4 cycles (3 accepts + 1 handoff).
REQ-020 i_valid while o_ready=0 SHALL be ignored; i_data SHALL not be sampled.
REQ-021 o_frame_cnt SHALL increment by 1 on each handoff, wrapping 8'hFF -> 8'h00.
REQ-022 i_flush=1 SHALL force state to S_B0 on the next edge, overriding any simultaneous accept or handoff; staging contents discarded; o_frame_cnt SHALL not increment on that edge.
REQ-023 i_flush in S_OUT SHALL drop the pending frame (o_valid->0) without handoff.
REQ-024 i_ready with o_valid=0 SHALL have no effect.

Reset
REQ-025 i_rst=1 SHALL immediately, without a clock, set state=S_B0, o_valid=0, o_ready=1 (state-decoded), o_p0=o_p1=o_p2=8'h00, staging=8'h00, o_frame_cnt=8'h00.
REQ-026 Reset asserted mid-frame SHALL discard all collected bytes; the first accept after release SHALL be byte 0.
REQ-027 Reset SHALL take priority over i_flush and all handshakes.

Verification
REQ-028 Reset, then bytes 55,77,01 on 3 consecutive cycles, i_ready=1 -> o_valid=1 for 1 cycle with o_p0=55, o_p1=77, o_p2=01; o_frame_cnt=01; o_ready=0 during that cycle.
REQ-029 Bytes F0,55,5A with i_ready=0 for 5 cycles then 1 -> o_valid held 6 cycles, outputs stable F0/55/5A, i_valid/i_data toggled meanwhile ignored, one increment of o_frame_cnt.
REQ-030 Bytes FF,88 then i_flush=1 together with i_valid=1/i_data=11 -> no o_valid; next bytes 11,22,33 -> o_p0=11, o_p1=22, o_p2=33.
REQ-031 Gapped i_valid (byte, idle 2 cycles, byte, idle, byte) -> frame assembled correctly; idle cycles do not advance state.
REQ-032 256 back-to-back frames -> o_frame_cnt returns to 00; handoffs spaced exactly 4 cycles.
REQ-033 i_rst pulsed between clock edges while in S_B2 -> outputs clear asynchronously; frame 01,02,03 after release -> o_p0=01, o_p1=02, o_p2=03.
